axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter: MEM_AW, 16, word-address width; memory holds 2**MEM_AW 32-bit words.
REQ-002 aclk  input  1  sole clock; all logic on rising edge.
REQ-003 areset  input  1  reset, asynchronous, active-high.
REQ-004 awid  input  4  write burst ID.
REQ-005 awaddr  input  32  write start byte address.
REQ-006 awlen  input  8  write beats minus one.
REQ-007 awsize  input  3  log2 bytes per beat.
REQ-008 awburst  input  2  0 FIXED, 1 INCR, 2 WRAP.
REQ-009 awlock/awcache/awprot  input  2/4/3  accepted, ignored.
REQ-010 awvalid / awready  input / output  1  AW handshake.
REQ-011 wid  input  4  ignored.
REQ-012 wdata / wstrb / wlast  input  32/4/1  write beat data, byte enables, last flag.
REQ-013 wvalid / wready  input / output  1  W handshake.
REQ-014 bid / bresp  output  4/2  write response ID, status.
REQ-015 bvalid / bready  output / input  1  B handshake.
REQ-016 arid / araddr / arlen / arsize / arburst  input  4/32/8/3/2  read request fields, same encoding as AW.
REQ-017 arlock/arcache/arprot  input  2/4/3  accepted, ignored.
REQ-018 arvalid / arready  input / output  1  AR handshake.
REQ-019 rid / rdata / rresp / rlast  output  4/32/2/1  read beat ID, data, status, last flag.
REQ-020 rvalid / rready  output / input  1  R handshake.

Function
REQ-021 FSM states SHALL be IDLE, RD, WR, WB; exactly one burst (read or write) is in service at a time.
REQ-022 In IDLE, arready and awready SHALL be driven combinationally; on a simultaneous arvalid&awvalid, grant SHALL alternate, tracked by a last-grant flag.
REQ-023 AR handshake SHALL capture id/addr/len/size/burst and enter RD; AW handshake SHALL capture the same and enter WR.
REQ-024 RD: rvalid=1 from the cycle after AR handshake; rdata = mem[addr[MEM_AW+1:2]] (asynchronous array read); one beat per cycle while rready=1; rlast=1 on beat index len; rid = captured ID.
REQ-025 While rvalid=1 and rready=0, rdata/rlast/rid/rresp SHALL remain stable.
REQ-026 After the rlast handshake the FSM SHALL return to IDLE.
REQ-027 WR: wready=1; each W handshake SHALL write the byte lanes selected by wstrb at the current address.
REQ-028 A write burst SHALL end after len+1 beats regardless of wlast; if wlast disagrees with the beat count on any beat, bresp SHALL be SLVERR (2'b10); writes are still performed.
REQ-029 WB: bvalid=1 with bid = captured ID; bready handshake -> IDLE.
REQ-030 Address update per beat: FIXED unchanged; INCR +(1<<size); WRAP +(1<<size) wrapping within the (len+1)*(1<<size) aligned region.
REQ-031 WRAP with len not in {1,3,7,15} SHALL be treated as INCR; burst encoding 3 SHALL be treated as INCR.
REQ-032 size > 2 SHALL give SLVERR on every R beat / the B response and SHALL suppress memory writes; the beat count is still honoured.
REQ-033 Address bits above MEM_AW+1 SHALL be ignored (aliasing); byte-offset bits SHALL not affect the word index.
REQ-034 rresp/bresp SHALL be OKAY (2'b00) otherwise.

Reset
REQ-035 areset SHALL force IDLE; arready/awready follow IDLE rules; rvalid, rlast, wready, bvalid = 0; rid, bid, rresp, bresp, rdata = 0; last-grant = write, so the first tie grants read.
REQ-036 Reset mid-burst SHALL abandon the burst without a response; memory contents are not cleared.

Structure
REQ-037 Burst-type encodings, resp encodings, and the FSM state enum SHALL live in the shared common package.
REQ-038 Next-address computation SHALL be a sub-module axi_burst_addr_gen (addr, len, size, burst -> next addr).

Verification
REQ-039 INCR write addr 0x100, len 3, size 2, data 1..4, full wstrb; then INCR read same -> rdata 1,2,3,4; rlast on 4th beat; bresp/rresp OKAY.
REQ-040 WRAP read addr 0x10C, len 3, size 2 -> words at 0x10C, 0x100, 0x104, 0x108.
REQ-041 awvalid and arvalid in the same cycle, twice back-to-back -> read granted first, write second.
REQ-042 Write len 1 with wlast on beat 0 -> two beats written, bresp SLVERR; wstrb 4'b0010 writes byte 1 only.
REQ-043 rready held low 3 cycles mid-burst -> R outputs stable; areset mid-read -> rvalid 0 next cycle, FSM IDLE.

Source files
------------

// File: rtl/axi_sram_slave_pkg.sv
// Shared types for the AXI SRAM slave: burst/resp encodings, FSM states and small helpers.
package axi_sram_slave_pkg;

    localparam int unsigned DataW = 32;
    localparam int          StrbW = 4;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StWb
    } state_e;

    // Only these lengths form a legal wrapping burst; anything else degrades to INCR.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for an AXI burst (FIXED, INCR, WRAP; reserved encodings act as INCR).
module axi_burst_addr_gen
    import axi_sram_slave_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] incr;
    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;

    always_comb begin
        incr      = 32'd1 << size;
        incr_addr = addr + incr;
        // Wrap region is (len+1) beats of 2**size bytes, naturally aligned.
        wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        next_addr = incr_addr;
        if (burst == BurstFixed) begin
            next_addr = addr;
        end else if ((burst == BurstWrap) && wrap_len_ok(len)) begin
            next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave fronting a single-port word SRAM; serves one read or write burst at a time.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int unsigned MEM_AW = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int unsigned MemWords = 2 ** MEM_AW;

    state_e              state_q;
    logic                last_grant_wr_q;
    logic [3:0]          id_q;
    logic [31:0]         addr_q;
    logic [7:0]          len_q;
    logic [7:0]          beat_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                size_err_q;
    logic                wlast_err_q;
    logic                rvalid_q;
    logic                wready_q;
    logic                bvalid_q;
    resp_e               rresp_q;
    resp_e               bresp_q;

    logic [31:0]         next_addr;
    logic [MEM_AW-1:0]   mem_idx;
    logic                idle;
    logic                ar_hs;
    logic                aw_hs;
    logic                beat_last;
    logic                mem_we;
    logic                unused_sideband;

    logic [DataW-1:0]    mem [MemWords];

    assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot, wid};

    // On a tie the channel that did not win last time gets the grant.
    assign idle      = (state_q == StIdle);
    assign arready   = idle && !(awvalid && !last_grant_wr_q);
    assign awready   = idle && !(arvalid && last_grant_wr_q);
    assign ar_hs     = arvalid && arready;
    assign aw_hs     = awvalid && awready;

    assign mem_idx   = addr_q[MEM_AW+1:2];
    assign beat_last = (beat_q == len_q);
    assign mem_we    = (state_q == StWr) && wvalid && wready_q && !size_err_q;

    assign rvalid    = rvalid_q;
    assign rdata     = rvalid_q ? mem[mem_idx] : '0;
    assign rlast     = rvalid_q && beat_last;
    assign rid       = id_q;
    assign rresp     = rresp_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bid       = id_q;
    assign bresp     = bresp_q;

    axi_burst_addr_gen u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q         <= StIdle;
            last_grant_wr_q <= 1'b1;
            id_q            <= '0;
            addr_q          <= '0;
            len_q           <= '0;
            beat_q          <= '0;
            size_q          <= '0;
            burst_q         <= '0;
            size_err_q      <= 1'b0;
            wlast_err_q     <= 1'b0;
            rvalid_q        <= 1'b0;
            wready_q        <= 1'b0;
            bvalid_q        <= 1'b0;
            rresp_q         <= RespOkay;
            bresp_q         <= RespOkay;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ar_hs) begin
                        id_q            <= arid;
                        addr_q          <= araddr;
                        len_q           <= arlen;
                        size_q          <= arsize;
                        burst_q         <= arburst;
                        beat_q          <= '0;
                        size_err_q      <= (arsize > 3'd2);
                        rresp_q         <= (arsize > 3'd2) ? RespSlverr : RespOkay;
                        rvalid_q        <= 1'b1;
                        last_grant_wr_q <= 1'b0;
                        state_q         <= StRd;
                    end else if (aw_hs) begin
                        id_q            <= awid;
                        addr_q          <= awaddr;
                        len_q           <= awlen;
                        size_q          <= awsize;
                        burst_q         <= awburst;
                        beat_q          <= '0;
                        size_err_q      <= (awsize > 3'd2);
                        wlast_err_q     <= 1'b0;
                        wready_q        <= 1'b1;
                        last_grant_wr_q <= 1'b1;
                        state_q         <= StWr;
                    end
                end
                StRd: begin
                    if (rready) begin
                        if (beat_last) begin
                            rvalid_q <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= next_addr;
                        end
                    end
                end
                StWr: begin
                    if (wvalid) begin
                        if (beat_last) begin
                            // Beat count, not wlast, closes the burst; a wrong wlast only flags SLVERR.
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (size_err_q || wlast_err_q || !wlast) ?
                                        RespSlverr : RespOkay;
                            state_q  <= StWb;
                        end else begin
                            if (wlast) begin
                                wlast_err_q <= 1'b1;
                            end
                            beat_q <= beat_q + 8'd1;
                            addr_q <= next_addr;
                        end
                    end
                end
                StWb: begin
                    if (bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Storage has no reset so contents survive areset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < StrbW; i++) begin
                if (wstrb[i]) begin
                    mem[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: reference memory model, expected-response queues, monitor.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    axi_sram_slave #(.MEM_AW(16)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awlock  (2'b00),
        .awcache (4'h0),
        .awprot  (3'h0),
        .awvalid (awvalid),
        .awready (awready),
        .wid     (4'h0),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arlock  (2'b00),
        .arcache (4'h0),
        .arprot  (3'h0),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      exp_r[$];
    bexp_t       exp_b[$];
    logic [31:0] ref_mem [65536];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic        wl [256];
    int          checks = 0;
    int          errors = 0;
    logic        last_wr_model;
    bit          rdy_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, expected DUT handshake", name);
    endtask

    // Byte address of beat n, straight from the burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input int n);
        longint ua;
        longint bytes;
        longint total;
        longint base;
        ua    = longint'(a);
        bytes = longint'(1) << size;
        total = (longint'(len) + 1) * bytes;
        if (burst == 2'd0) return a;
        if ((burst == 2'd2) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            base = (ua / total) * total;
            return 32'(base + ((ua - base) + longint'(n) * bytes) % total);
        end
        return 32'(ua + longint'(n) * bytes);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % 32'd65536);
    endfunction

    task automatic model_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        rbeat_t e;
        for (int n = 0; n <= int'(len); n++) begin
            e.id   = id;
            e.data = ref_mem[word_of(beat_addr(a, len, size, burst, n))];
            e.resp = (size > 3'd2) ? 2'b10 : 2'b00;
            e.last = (n == int'(len));
            exp_r.push_back(e);
        end
    endtask

    task automatic model_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        bexp_t b;
        bit    err;
        int    idx;
        err = (size > 3'd2);
        for (int n = 0; n <= int'(len); n++) begin
            if (wl[n] != (n == int'(len))) err = 1'b1;
            if (size <= 3'd2) begin
                idx = word_of(beat_addr(a, len, size, burst, n));
                for (int i = 0; i < 4; i++) begin
                    if (ws[n][i]) ref_mem[idx][8*i +: 8] = wd[n][8*i +: 8];
                end
            end
        end
        b.id   = id;
        b.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(b);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    endtask

    task automatic wait_aw_hs();
        int n = 0;
        @(negedge aclk);
        while (!awready && n < 500) begin @(negedge aclk); n++; end
        if (!awready) fail_timeout("aw_handshake");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        last_wr_model = 1'b1;
    endtask

    task automatic wait_ar_hs();
        int n = 0;
        @(negedge aclk);
        while (!arready && n < 500) begin @(negedge aclk); n++; end
        if (!arready) fail_timeout("ar_handshake");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        last_wr_model = 1'b0;
    endtask

    task automatic send_w(input logic [7:0] len);
        int k;
        for (int n = 0; n <= int'(len); n++) begin
            wvalid = 1'b0;
            if ($urandom_range(0, 2) == 0) begin @(posedge aclk); #1; end
            wvalid = 1'b1; wdata = wd[n]; wstrb = ws[n]; wlast = wl[n];
            k = 0;
            @(negedge aclk);
            while (!wready && k < 500) begin @(negedge aclk); k++; end
            if (!wready) fail_timeout("w_handshake");
            @(posedge aclk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic wait_q(input bit want_r, input bit want_b);
        int n = 0;
        while (((want_r && exp_r.size() != 0) || (want_b && exp_b.size() != 0)) && n < 3000) begin
            @(posedge aclk); #1;
            n++;
        end
        if ((want_r && exp_r.size() != 0) || (want_b && exp_b.size() != 0)) begin
            fail_timeout("response_drain");
            if (want_r) exp_r.delete();
            if (want_b) exp_b.delete();
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        model_write(id, a, len, size, burst);
        send_aw(id, a, len, size, burst);
        wait_aw_hs();
        send_w(len);
        wait_q(1'b0, 1'b1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        model_read(id, a, len, size, burst);
        send_ar(id, a, len, size, burst);
        wait_ar_hs();
        wait_q(1'b1, 1'b0);
    endtask

    // Simultaneous AR and AW; the model's last-grant flag decides who must win.
    task automatic tie_pair(input logic [3:0] r_id, input logic [31:0] r_a, input logic [7:0] r_len,
                            input logic [3:0] w_id, input logic [31:0] w_a, input logic [7:0] w_len);
        bit read_first;
        read_first = last_wr_model;
        if (read_first) begin
            model_read(r_id, r_a, r_len, 3'd2, 2'd1);
            model_write(w_id, w_a, w_len, 3'd2, 2'd1);
        end else begin
            model_write(w_id, w_a, w_len, 3'd2, 2'd1);
            model_read(r_id, r_a, r_len, 3'd2, 2'd1);
        end
        send_ar(r_id, r_a, r_len, 3'd2, 2'd1);
        send_aw(w_id, w_a, w_len, 3'd2, 2'd1);
        @(negedge aclk);
        check("tie_arready", 64'(arready), 64'(read_first));
        check("tie_awready", 64'(awready), 64'(!read_first));
        @(posedge aclk); #1;
        if (read_first) begin
            arvalid = 1'b0;
            last_wr_model = 1'b0;
            wait_q(1'b1, 1'b0);
            wait_aw_hs();
            send_w(w_len);
            wait_q(1'b0, 1'b1);
        end else begin
            awvalid = 1'b0;
            last_wr_model = 1'b1;
            send_w(w_len);
            wait_q(1'b0, 1'b1);
            wait_ar_hs();
            wait_q(1'b1, 1'b0);
        end
    endtask

    task automatic fill_w(input logic [7:0] len, input logic [31:0] first, input bit rnd);
        for (int n = 0; n <= int'(len); n++) begin
            wd[n] = rnd ? $urandom : first + 32'(n);
            ws[n] = 4'hF;
            wl[n] = (n == int'(len));
        end
    endtask

    // Random ready generation for R and B.
    initial begin
        forever begin
            @(posedge aclk); #1;
            if (rdy_rand) begin
                rready = ($urandom_range(0, 3) != 0);
                bready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: pops the scoreboard on each R/B handshake and checks R stability under stall.
    initial begin : monitor
        rbeat_t      e;
        bexp_t       b;
        bit          stall;
        logic [38:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stall = 1'b0;
                continue;
            end
            if (stall) check("r_stable", 64'({rvalid, rid, rdata, rresp, rlast}), 64'({1'b1, held}));
            stall = rvalid && !rready;
            held  = {rid, rdata, rresp, rlast};
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    check("r_extra_beat", 64'(rvalid), 64'(0));
                end else begin
                    e = exp_r.pop_front();
                    check("r_beat", 64'({rid, rdata, rresp, rlast}), 64'({e.id, e.data, e.resp, e.last}));
                end
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    check("b_extra_resp", 64'(bvalid), 64'(0));
                end else begin
                    b = exp_b.pop_front();
                    check("b_resp", 64'({bid, bresp}), 64'({b.id, b.resp}));
                end
            end
        end
    end

    initial begin : stimulus
        logic [3:0]  id;
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          k;
        int          flip;

        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        last_wr_model = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_rlast", 64'(rlast), 64'(0));
        check("rst_wready", 64'(wready), 64'(0));
        check("rst_bvalid", 64'(bvalid), 64'(0));
        check("rst_rid", 64'(rid), 64'(0));
        check("rst_bid", 64'(bid), 64'(0));
        check("rst_rresp", 64'(rresp), 64'(0));
        check("rst_bresp", 64'(bresp), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_arready", 64'(arready), 64'(1));
        check("rst_awready", 64'(awready), 64'(1));
        @(posedge aclk); #1;
        areset = 1'b0;
        rdy_rand = 1'b1;

        // Preload words 0..127 so every later read is of known data.
        fill_w(8'd127, 32'd0, 1'b1);
        do_write(4'h1, 32'h0, 8'd127, 3'd2, 2'd1);

        fill_w(8'd3, 32'd1, 1'b0);
        do_write(4'h3, 32'h100, 8'd3, 3'd2, 2'd1);
        do_read(4'h5, 32'h100, 8'd3, 3'd2, 2'd1);
        do_read(4'h6, 32'h10C, 8'd3, 3'd2, 2'd2);

        wd[0] = 32'hA5A5_A5A5; ws[0] = 4'b0010; wl[0] = 1'b1;
        wd[1] = 32'h1234_5678; ws[1] = 4'hF;    wl[1] = 1'b0;
        do_write(4'h7, 32'h40, 8'd1, 3'd2, 2'd1);
        do_read(4'h8, 32'h40, 8'd1, 3'd2, 2'd1);

        // Directed R stall: two beats, then rready low for three cycles.
        @(negedge aclk);
        rdy_rand = 1'b0;
        @(posedge aclk); #1;
        rready = 1'b0;
        bready = 1'b1;
        model_read(4'hA, 32'h20, 8'd7, 3'd2, 2'd1);
        send_ar(4'hA, 32'h20, 8'd7, 3'd2, 2'd1);
        wait_ar_hs();
        rready = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        rready = 1'b0;
        repeat (3) begin @(posedge aclk); #1; end
        rready = 1'b1;
        wait_q(1'b1, 1'b0);

        // Reset in the middle of a read burst.
        model_read(4'h9, 32'h0, 8'd15, 3'd2, 2'd1);
        send_ar(4'h9, 32'h0, 8'd15, 3'd2, 2'd1);
        wait_ar_hs();
        repeat (3) begin @(posedge aclk); #1; end
        rready = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        check("midrst_rvalid", 64'(rvalid), 64'(0));
        check("midrst_rlast", 64'(rlast), 64'(0));
        check("midrst_arready", 64'(arready), 64'(1));
        check("midrst_awready", 64'(awready), 64'(1));
        exp_r.delete();
        last_wr_model = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("postrst_rvalid", 64'(rvalid), 64'(0));
        rdy_rand = 1'b1;
        @(posedge aclk); #1;

        // Arbitration ties: fresh after reset, again back-to-back, then after a lone read.
        fill_w(8'd3, 32'hC0DE_0000, 1'b0);
        tie_pair(4'h2, 32'h100, 8'd3, 4'hB, 32'h180, 8'd3);
        fill_w(8'd1, 32'hBEEF_0000, 1'b0);
        tie_pair(4'h4, 32'h180, 8'd3, 4'hC, 32'h1C0, 8'd1);
        do_read(4'hD, 32'h1C0, 8'd1, 3'd2, 2'd1);
        fill_w(8'd2, 32'hFACE_0000, 1'b0);
        tie_pair(4'hE, 32'h1C0, 8'd1, 4'hF, 32'h80, 8'd2);

        for (int t = 0; t < 60; t++) begin
            id    = 4'($urandom);
            k     = int'($urandom_range(0, 8));
            len   = (k == 8) ? 8'd15 : 8'(k);
            size  = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 3));
            a     = 32'($urandom_range(0, 95) * 4 + $urandom_range(0, 3)) |
                    ($urandom & 32'hFFFC_0000);
            if ($urandom_range(0, 1) == 1) begin
                flip = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, k)) : -1;
                for (int n = 0; n <= int'(len); n++) begin
                    wd[n] = $urandom;
                    ws[n] = 4'($urandom);
                    wl[n] = (n == int'(len)) ^ (n == flip);
                end
                do_write(id, a, len, size, burst);
            end else begin
                do_read(id, a, len, size, burst);
            end
        end

        repeat (5) @(posedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
